// File: rtl/ama_riscv_mem_arb.sv
// ama_riscv_mem_arb: grants the single memory port to the icache or dcache for one BEATS-beat line transaction.
// Define MEM_ARB_RR_EN for round-robin arbitration; the default is fixed priority with dcache over icache.
module ama_riscv_mem_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BEATS  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req_valid,
    output logic              ic_req_ready,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_rsp_valid,
    input  logic              ic_rsp_ready,
    output logic [DATA_W-1:0] ic_rsp_data,
    input  logic              dc_req_valid,
    output logic              dc_req_ready,
    input  logic [ADDR_W-1:0] dc_req_addr,
    input  logic              dc_req_we,
    input  logic              dc_wdata_valid,
    output logic              dc_wdata_ready,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_rsp_valid,
    input  logic              dc_rsp_ready,
    output logic [DATA_W-1:0] dc_rsp_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_we,
    output logic              mem_wdata_valid,
    input  logic              mem_wdata_ready,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rsp_valid,
    output logic              mem_rsp_ready,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              err_stray
);
    localparam int CW = $clog2(BEATS);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, RD = 2'd2, WR = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              own_q, own_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              win, rd, wr, beat, last;

    // own_q / win: 1 = dcache, 0 = icache
`ifdef MEM_ARB_RR_EN
    logic last_q, last_d;
    assign win = (ic_req_valid && dc_req_valid) ? !last_q : dc_req_valid;
`else
    assign win = dc_req_valid;
`endif

    assign rd              = state_q == RD;
    assign wr              = state_q == WR;
    assign mem_req_valid   = state_q == REQ;
    assign mem_req_addr    = addr_q;
    assign mem_req_we      = we_q;
    assign ic_req_ready    = mem_req_valid && !own_q && mem_req_ready;
    assign dc_req_ready    = mem_req_valid && own_q && mem_req_ready;
    assign ic_rsp_valid    = rd && !own_q && mem_rsp_valid;
    assign dc_rsp_valid    = rd && own_q && mem_rsp_valid;
    assign mem_rsp_ready   = rd && (own_q ? dc_rsp_ready : ic_rsp_ready);
    assign ic_rsp_data     = mem_rsp_data;
    assign dc_rsp_data     = mem_rsp_data;
    assign mem_wdata_valid = wr && dc_wdata_valid;
    assign dc_wdata_ready  = wr && mem_wdata_ready;
    assign mem_wdata       = dc_wdata;
    assign err_stray       = err_q;
    assign beat            = (rd && mem_rsp_valid && mem_rsp_ready) || (mem_wdata_valid && mem_wdata_ready);
    assign last            = beat && cnt_q == CW'(BEATS - 1);

    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        addr_d  = addr_q;
        we_d    = we_q;
        cnt_d   = beat ? cnt_q + CW'(1) : cnt_q;
        err_d   = err_q || (mem_rsp_valid && !rd);
`ifdef MEM_ARB_RR_EN
        last_d  = last_q;
`endif
        if (state_q == IDLE && (ic_req_valid || dc_req_valid)) begin
            state_d = REQ;
            own_d   = win;
            addr_d  = win ? dc_req_addr : ic_req_addr;
            we_d    = win && dc_req_we;
`ifdef MEM_ARB_RR_EN
            last_d  = win;
`endif
        end
        if (mem_req_valid && mem_req_ready) state_d = we_q ? WR : RD;
        if (last) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            own_q   <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= 1'b0;
        else     last_q <= last_d;
    end
`endif
endmodule
